// File: rtl/mantissa_mul_iter_mp_if.sv
// Operand/result bundle for the iterative mantissa multiplier.
// No latency of its own; pure wiring.
// Producer side holds in_valid until in_ready; consumer stalls results via out_ready.
interface mantissa_mul_iter_mp_if #(
  parameter int W = 28
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     op;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic           busy;

  // Multiplier side
  modport slave (
    input  in_valid, A, B, op, flush, out_ready,
    output in_ready, out_valid, out, busy
  );

  // Requester / result consumer side
  modport master (
    output in_valid, A, B, op, flush, out_ready,
    input  in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/mantissa_mul_iter_mp.sv
// Iterative multi-precision unsigned multiplier: one row of four CHUNKxCHUNK products per cycle.
// Latency: accept edge T0, result valid after edge T4; 1 result per 5 cycles back-to-back.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&out_ready.
module mantissa_mul_iter_mp #(
  parameter int W = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mantissa_mul_iter_mp_if.slave  bus
);

  localparam int CHUNK = W / 4;
  localparam int PW    = 2 * CHUNK;
  localparam int AW    = 2 * W;

  generate
    if (W % 4 != 0) begin : g_bad_width
      $error("mantissa_mul_iter_mp: W must be a multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   acc_q, acc_d;

  logic            in_ready;
  logic            accept;
  logic [AW-1:0]   col_sum;
  logic [PW-1:0]   a_ch;
  logic [PW-1:0]   b_ch;
  logic [PW-1:0]   prod;
  logic            keep;

  // Sum of the gated partial products for the current B chunk, each at offset (i+col)*CHUNK.
  // Lane modes just drop cross-lane terms, so lane results land in their own fields carry-free.
  always_comb begin
    col_sum = '0;
    a_ch    = '0;
    b_ch    = '0;
    prod    = '0;
    keep    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ch = {{CHUNK{1'b0}}, a_q[i*CHUNK +: CHUNK]};
      b_ch = {{CHUNK{1'b0}}, b_q[int'(col_q)*CHUNK +: CHUNK]};
      prod = a_ch * b_ch;
      case (op_q)
        2'b01:   keep = ((i / 2) == (int'(col_q) / 2));
        2'b10:   keep = (i == int'(col_q));
        default: keep = 1'b1;
      endcase
      if (keep) begin
        col_sum = col_sum + ({{(AW-PW){1'b0}}, prod} << ((i + int'(col_q)) * CHUNK));
      end
    end
  end

  // Next-state and operand capture; flush overrides every handshake in the same cycle.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    accept   = bus.in_valid & in_ready;

    if (bus.flush) begin
      state_d = IDLE;
      col_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = CALC;
            a_d     = bus.A;
            b_d     = bus.B;
            op_d    = bus.op;
            acc_d   = '0;
            col_d   = 2'd0;
          end
        end
        CALC: begin
          acc_d = acc_q + col_sum;
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              state_d = CALC;
              a_d     = bus.A;
              b_d     = bus.B;
              op_d    = bus.op;
              acc_d   = '0;
              col_d   = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = 2'd0;
        end
      endcase
    end
  end

  // State, column counter, captured operands and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CALC);
  assign bus.out       = acc_q;

endmodule

// File: tb/tb_mantissa_mul_iter_mp.sv
// Self-checking bench for mantissa_mul_iter_mp (W=28): directed table, corner sequences, random.
// Expected results come from constants or a lane-arithmetic reference model.
// Drives inputs #1 after posedge, samples on negedge.
module tb_mantissa_mul_iter_mp;

  localparam int W = 28;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mantissa_mul_iter_mp_if #(.W(W)) bus ();

  mantissa_mul_iter_mp #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Reference: full product, or independent lane products packed into their fields.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    longint unsigned r, la, lb, m;
    r = 0;
    if (op == 2'b01) begin
      m = (64'd1 << (W/2)) - 1;
      for (int k = 0; k < 2; k++) begin
        la = (longint'(a) >> (k*W/2)) & m;
        lb = (longint'(b) >> (k*W/2)) & m;
        r  = r | ((la * lb) << (k*W));
      end
    end else if (op == 2'b10) begin
      m = (64'd1 << (W/4)) - 1;
      for (int k = 0; k < 4; k++) begin
        la = (longint'(a) >> (k*W/4)) & m;
        lb = (longint'(b) >> (k*W/4)) & m;
        r  = r | ((la * lb) << (k*W/2));
      end
    end else begin
      r = longint'(a) * longint'(b);
    end
    return r[2*W-1:0];
  endfunction

  task automatic check_v(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
  endtask

  // Waits for in_ready, lets the accept edge pass, then scrambles the operand pins.
  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check_b({name, "_accept_timeout"}, bus.in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
    bus.op       = 2'($urandom);
  endtask

  // Called #1 after the accept edge; result must appear on the 5th following negedge.
  task automatic wait_result(input string name, input logic [2*W-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    n++;
    check_b({name, "_busy_calc"}, bus.busy, 1'b1);
    check_b({name, "_in_ready_calc"}, bus.in_ready, 1'b0);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_i({name, "_latency"}, n, 5);
    check_b({name, "_busy_done"}, bus.busy, 1'b0);
    check_v({name, "_out"}, bus.out, exp);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] exp);
    drive_req(op, a, b);
    wait_accept(name);
    wait_result(name, exp);
    release_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   ra, rb;
    logic [1:0]     rop;
    logic [2*W-1:0] rexp;
    logic [2*W-1:0] full_ff;
    int             dly;

    checks = 0;
    errors = 0;
    full_ff = 56'hFFFFFFE0000001;

    vecs[0] = '{"t1_full",       2'b00, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001};
    vecs[1] = '{"t2_half",       2'b01, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFF8001FFF8001};
    vecs[2] = '{"t3_quarter",    2'b10, 28'hFFFFFFF, 28'hFFFFFFF, {4{14'h3F01}}};
    // Cross-chunk term 1*3 at offset 7 is gated in quarter mode; only lane 0 (1*3) survives.
    vecs[3] = '{"t3_q_small",    2'b10, 28'h0000081, 28'h0000003, 56'h3};
    vecs[4] = '{"full_small",    2'b00, 28'h0000081, 28'h0000003, 56'h183};
    vecs[5] = '{"op11_full",     2'b11, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001};
    vecs[6] = '{"half_lanes",    2'b01, {14'd7, 14'd9}, {14'd11, 14'd13}, {28'd77, 28'd117}};
    vecs[7] = '{"quarter_lanes", 2'b10, {7'd2, 7'd3, 7'd4, 7'd5}, {7'd6, 7'd7, 7'd8, 7'd9},
                {14'd12, 14'd21, 14'd32, 14'd45}};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.op        = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_b("rst_out_valid", bus.out_valid, 1'b0);
    check_v("rst_out", bus.out, '0);
    check_b("rst_busy", bus.busy, 1'b0);
    check_b("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Stall in DONE for 10 cycles, then back-to-back accept on the releasing edge
    drive_req(2'b00, 28'hFFFFFFF, 28'hFFFFFFF);
    wait_accept("t4");
    wait_result("t4_first", full_ff);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_v("t4_hold_out", bus.out, full_ff);
      check_b("t4_hold_valid", bus.out_valid, 1'b1);
      check_b("t4_hold_in_ready", bus.in_ready, 1'b0);
    end
    drive_req(2'b00, 28'd3, 28'd5);
    bus.out_ready = 1'b1;
    #1;
    check_b("t4_in_ready_on_release", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    wait_result("t4_b2b", 56'd15);
    release_result();

    // Flush in the second CALC cycle
    drive_req(2'b00, 28'hFFFFFFF, 28'hFFFFFFF);
    wait_accept("t5");
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check_b("t5_busy_after_flush", bus.busy, 1'b0);
    check_b("t5_in_ready_after_flush", bus.in_ready, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (bus.out_valid) seen = 1'b1;
        @(negedge clk);
      end
      check_b("t5_out_valid_never", seen, 1'b0);
    end
    @(posedge clk);
    #1;
    do_op("t5_after", 2'b00, 28'd3, 28'd5, 56'd15);

    // Reset mid-CALC
    drive_req(2'b00, 28'hFFFFFFF, 28'hFFFFFFF);
    wait_accept("t6a");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_b("t6a_out_valid", bus.out_valid, 1'b0);
    check_v("t6a_out", bus.out, '0);
    check_b("t6a_in_ready", bus.in_ready, 1'b1);
    check_b("t6a_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in DONE
    drive_req(2'b01, 28'hFFFFFFF, 28'hFFFFFFF);
    wait_accept("t6b");
    wait_result("t6b", 56'hFFF8001FFF8001);
    rst_n = 1'b0;
    #1;
    check_b("t6b_out_valid", bus.out_valid, 1'b0);
    check_v("t6b_out", bus.out, '0);
    check_b("t6b_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random regression over all op codes with random consumer stalls
    for (int n = 0; n < 150; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rop  = 2'($urandom_range(0, 3));
      rexp = model(ra, rb, rop);
      dly  = $urandom_range(0, 3);
      drive_req(rop, ra, rb);
      wait_accept("rand");
      wait_result("rand", rexp);
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        check_v("rand_hold", bus.out, rexp);
      end
      release_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
